spi_reg_decoder: RTL and testbench
==================================

# spi_reg_decoder

Byte-level command decoder that sits directly downstream of the SPI slave receiver. It consumes each received byte (one-cycle valid pulse) together with the chip-select level, parses a small framed write protocol, and updates a bank of 8-bit control registers that drive LEDs and other fabric logic. It is receive-only: there is no readback path, because the upstream stage has no MISO.

## Interface
- NUM_REGS, 4, number of 8-bit registers; legal range 1..16
- sys_clk  in  1  system clock, same OSCH-derived domain as the receiver
- sys_rst  in  1  reset; synchronous, active-high
- rx_data  in  8  received byte; valid only in the rx_valid cycle
- rx_valid  in  1  one-cycle pulse, byte complete
- rx_cs  in  1  chip select level, active-low (1 = deselected, frame boundary)
- reg_q  out  8*NUM_REGS  register bank; register n at bits [8n+7:8n]
- wr_stb  out  1  one-cycle pulse per register write
- wr_addr  out  4  address of the write flagged by wr_stb
- frame_err  out  1  one-cycle pulse on protocol error
- err_cnt  out  8  saturating error count (present only with SPI_REG_ERRCNT_EN)

## Operation
- Frame: rx_cs low. First byte is the command; bits [7:4] are the opcode and bits [3:0] the address.
- Opcode 0x1 WRITE: each following byte is written to reg[addr]; addr auto-increments by 1 per byte.
- Opcode 0x2 CLEAR: all registers are zeroed in one cycle, with no wr_stb. Any further bytes in the frame are errors.
- Opcode 0x0 NOP: further bytes are ignored silently.
- Any other opcode is an error.
- Error events:
  - Undefined opcode.
  - Command address ≥ NUM_REGS.
  - Auto-increment passes NUM_REGS−1 (no wrap).
  - Data byte after CLEAR.
- On an error: pulse frame_err, drop the byte, enter DRAIN.
- States:
  - IDLE → CMD when rx_cs falls.
  - CMD: on rx_valid, decode. WRITE goes to DATA, CLEAR goes to DONE, NOP goes to DONE, error goes to DRAIN.
  - DATA: on rx_valid, write and increment; out-of-range goes to DRAIN.
  - DONE: a byte goes to DRAIN with an error, except after NOP.
  - DRAIN: ignore bytes.
  - Every state returns to IDLE whenever rx_cs = 1.
- A frame with zero bytes, or a WRITE command with no data, is legal and causes no error and no change.
- Address arithmetic is 5 bits wide internally, so that the overflow at 15+1 is detected and never wraps.

## Timing
- Reset values: reg_q all 0, wr_stb 0, wr_addr 0, frame_err 0, err_cnt 0, state IDLE, address pointer 0.
- rx_data is sampled only in the rx_valid cycle.
- reg_q, wr_stb, wr_addr and frame_err all update on the first sys_clk edge after rx_valid, so latency is 1 cycle.
- wr_stb and wr_addr are registered and coincide with the new reg_q value.
- rx_valid and rx_cs rising in the same cycle: the byte is fully processed (write or error), and the next state is IDLE.
- rx_valid while in IDLE (rx_cs already high): ignored.
- Back-to-back rx_valid on consecutive cycles must be accepted. The upstream receiver cannot produce this, but the bench drives it.
- sys_rst mid-frame: all state and registers return to their reset values. The remainder of the frame is treated as DRAIN until rx_cs = 1, so a partial frame is never decoded as a command.

## Configuration
- SPI_REG_ERRCNT_EN defined: err_cnt is present and increments on each frame_err pulse, saturating at 0xFF. It is cleared only by sys_rst and is not affected by CLEAR.
- SPI_REG_ERRCNT_EN undefined: the err_cnt port and its logic are absent; frame_err is unchanged.

## Structure
- Shared package spi_pkg holds:
  - State enum: IDLE, CMD, DATA, DONE, DRAIN.
  - Opcode constants OP_NOP = 0x0, OP_WRITE = 0x1, OP_CLEAR = 0x2.
  - Byte width constant 8.
- One natural sub-module is spi_reg_bank: NUM_REGS×8 registers with write-enable/address/data inputs and a synchronous clear-all. The decoder FSM stays in the top.

## Test plan
- Frame 0x12, 0xAA, 0x55 with NUM_REGS = 4 → reg2 = 0xAA, reg3 = 0x55; wr_stb pulses with wr_addr 2 then 3; frame_err stays 0.
- Frame 0x13, 0x11, 0x22 → reg3 = 0x11; the second byte raises frame_err; reg0 is unchanged (no wrap); err_cnt = 1 with the macro defined.
- Registers preloaded, then frame 0x20 → all reg_q = 0 one cycle after rx_valid; no wr_stb.
- Frame 0x70, 0x01 → frame_err on the command byte; the byte 0x01 is drained; no register changes.
- rx_cs rises in the same cycle as the rx_valid of 0x10's data byte 0x5A → reg0 = 0x5A; the next frame 0x11, 0x33 decodes normally, writing reg1 = 0x33.
- sys_rst asserted after command 0x10, then byte 0x77 arrives before rx_cs rises → all registers stay 0 and no wr_stb.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI register decoder: decoder
//               state encoding, command opcodes and the byte width.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int BYTE_W = 8;

    // Command opcodes carried in bits [7:4] of the first byte of a frame
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_CLEAR = 4'h2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        DATA  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bank
// Description : NUM_REGS x 8-bit control register bank with a single write
//               port and a synchronous clear-all.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_clr         - zero every register on the next edge
//               i_we          - write enable for i_addr / i_data
//               i_addr        - register index (caller keeps it < NUM_REGS)
//               i_data        - write data
//               o_reg_q       - flattened bank, register n at [8n+7:8n]
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_we,
    input  logic [3:0]                 i_addr,
    input  logic [BYTE_W-1:0]          i_data,
    output logic [BYTE_W*NUM_REGS-1:0] o_reg_q
);

    generate
        for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
            logic [BYTE_W-1:0] r_q;

            always_ff @(posedge clk) begin
                if (rst || i_clr) begin
                    r_q <= '0;
                end else if (i_we && (i_addr == 4'(n))) begin
                    r_q <= i_data;
                end
            end

            assign o_reg_q[BYTE_W*n +: BYTE_W] = r_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_reg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_decoder
// Description : Byte-level command decoder behind the SPI slave receiver.
//               Parses framed WRITE / CLEAR / NOP commands and updates a
//               bank of 8-bit control registers. Receive-only.
// Ports       : sys_clk, sys_rst - clock, synchronous active-high reset
//               rx_data/rx_valid - received byte and its one-cycle strobe
//               rx_cs            - chip select, active-low frame envelope
//               reg_q            - register bank, register n at [8n+7:8n]
//               wr_stb/wr_addr   - one pulse per register write + its index
//               frame_err        - one-cycle pulse on a protocol error
//               err_cnt          - saturating error count (optional)
// Config      : define SPI_REG_ERRCNT_EN to add the err_cnt port and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_decoder
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [BYTE_W-1:0]          rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_cs,
    output logic [BYTE_W*NUM_REGS-1:0] reg_q,
    output logic                       wr_stb,
    output logic [3:0]                 wr_addr,
`ifdef SPI_REG_ERRCNT_EN
    output logic [7:0]                 err_cnt,
`endif
    output logic                       frame_err
);

    localparam logic [4:0] C_NUM_REGS = 5'(NUM_REGS);

    state_t      r_state;
    logic [4:0]  r_addr;      // 5 bits so 15+1 is seen as out of range
    logic        r_nop;       // DONE was entered through a NOP
    logic        r_cs_armed;  // rx_cs has been seen high since reset
    logic        r_wr_stb;
    logic [3:0]  r_wr_addr;
    logic        r_frame_err;

    state_t      w_state_n;
    logic [4:0]  w_addr_n;
    logic        w_nop_n;
    logic        w_err;
    logic        w_we;
    logic        w_clr;
    logic [3:0]  w_opcode;
    logic [4:0]  w_cmd_addr;

    assign w_opcode   = rx_data[7:4];
    assign w_cmd_addr = {1'b0, rx_data[3:0]};

    // Byte decode. Writes and clears are presented to the bank in the
    // rx_valid cycle so the bank and the strobe registers update together.
    always_comb begin
        w_state_n = r_state;
        w_addr_n  = r_addr;
        w_nop_n   = r_nop;
        w_err     = 1'b0;
        w_we      = 1'b0;
        w_clr     = 1'b0;

        case (r_state)
            IDLE: begin
                // Only a true falling edge opens a frame; a frame already in
                // progress when reset releases is ignored until rx_cs rises.
                if (r_cs_armed && !rx_cs) begin
                    w_state_n = CMD;
                end
            end
            CMD: begin
                if (rx_valid) begin
                    if (w_opcode != OP_NOP && w_opcode != OP_WRITE &&
                        w_opcode != OP_CLEAR) begin
                        w_err     = 1'b1;
                        w_state_n = DRAIN;
                    end else if (w_cmd_addr >= C_NUM_REGS) begin
                        w_err     = 1'b1;
                        w_state_n = DRAIN;
                    end else if (w_opcode == OP_WRITE) begin
                        w_addr_n  = w_cmd_addr;
                        w_state_n = DATA;
                    end else if (w_opcode == OP_CLEAR) begin
                        w_clr     = 1'b1;
                        w_nop_n   = 1'b0;
                        w_state_n = DONE;
                    end else begin
                        w_nop_n   = 1'b1;
                        w_state_n = DONE;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (r_addr >= C_NUM_REGS) begin
                        w_err     = 1'b1;
                        w_state_n = DRAIN;
                    end else begin
                        w_we     = 1'b1;
                        w_addr_n = r_addr + 5'd1;
                    end
                end
            end
            DONE: begin
                if (rx_valid && !r_nop) begin
                    w_err     = 1'b1;
                    w_state_n = DRAIN;
                end
            end
            DRAIN: begin
                w_state_n = DRAIN;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // Deselect always ends the frame; a byte in the same cycle has
        // already been handled above.
        if (rx_cs) begin
            w_state_n = IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_nop       <= 1'b0;
            r_cs_armed  <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_addr      <= w_addr_n;
            r_nop       <= w_nop_n;
            r_cs_armed  <= rx_cs;
            r_wr_stb    <= w_we;
            r_frame_err <= w_err;
            if (w_we) begin
                r_wr_addr <= r_addr[3:0];
            end
        end
    end

    spi_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_clr   (w_clr),
        .i_we    (w_we),
        .i_addr  (r_addr[3:0]),
        .i_data  (rx_data),
        .o_reg_q (reg_q)
    );

    assign wr_stb    = r_wr_stb;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;

`ifdef SPI_REG_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Counts in step with frame_err; CLEAR does not touch it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_decoder
// Description : Directed self-checking bench for spi_reg_decoder with
//               NUM_REGS = 4. Follows SPI_REG_ERRCNT_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_decoder;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_cs = 1'b1;
    logic [31:0] reg_q;
    logic        wr_stb;
    logic [3:0]  wr_addr;
    logic        frame_err;
`ifdef SPI_REG_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    spi_reg_decoder #(
        .NUM_REGS (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_cs     (rx_cs),
        .reg_q     (reg_q),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
`ifdef SPI_REG_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .frame_err (frame_err)
    );

    // Stimulus primitives. Each ends at posedge+1, where outputs are sampled.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic cs_low();
        tick();
        rx_cs = 1'b0;
        tick();
        tick();
    endtask

    task automatic cs_high();
        tick();
        rx_cs = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        n_checks++;
        if (reg_q !== 32'h0) begin
            n_errors++; $display("FAIL reset_reg_q got=%h exp=%h", reg_q, 32'h0);
        end
        n_checks++;
        if (wr_stb !== 1'b0 || wr_addr !== 4'h0 || frame_err !== 1'b0) begin
            n_errors++; $display("FAIL reset_outputs got stb=%b addr=%h err=%b exp 0/0/0",
                                 wr_stb, wr_addr, frame_err);
        end
`ifdef SPI_REG_ERRCNT_EN
        n_checks++;
        if (err_cnt !== 8'h00) begin
            n_errors++; $display("FAIL reset_err_cnt got=%h exp=00", err_cnt);
        end
`endif
    endtask

    task automatic test_write();
        cs_low();
        send_byte(8'h12);
        n_checks++;
        if (wr_stb !== 1'b0 || frame_err !== 1'b0) begin
            n_errors++; $display("FAIL write_cmd got stb=%b err=%b exp 0/0", wr_stb, frame_err);
        end
        send_byte(8'hAA);
        n_checks++;
        if (wr_stb !== 1'b1 || wr_addr !== 4'h2 || reg_q !== 32'h00AA_0000) begin
            n_errors++; $display("FAIL write_b0 got stb=%b addr=%h q=%h exp 1/2/00aa0000",
                                 wr_stb, wr_addr, reg_q);
        end
        send_byte(8'h55);
        n_checks++;
        if (wr_stb !== 1'b1 || wr_addr !== 4'h3 || reg_q !== 32'h55AA_0000 || frame_err !== 1'b0) begin
            n_errors++; $display("FAIL write_b1 got stb=%b addr=%h q=%h err=%b exp 1/3/55aa0000/0",
                                 wr_stb, wr_addr, reg_q, frame_err);
        end
        tick();
        n_checks++;
        if (wr_stb !== 1'b0) begin
            n_errors++; $display("FAIL write_stb_pulse got=%b exp=0", wr_stb);
        end
        cs_high();
    endtask

    task automatic test_overflow();
        cs_low();
        send_byte(8'h13);
        send_byte(8'h11);
        n_checks++;
        if (wr_stb !== 1'b1 || wr_addr !== 4'h3 || reg_q !== 32'h11AA_0000) begin
            n_errors++; $display("FAIL ovf_b0 got stb=%b addr=%h q=%h exp 1/3/11aa0000",
                                 wr_stb, wr_addr, reg_q);
        end
        send_byte(8'h22);
        n_checks++;
        if (frame_err !== 1'b1 || wr_stb !== 1'b0 || reg_q !== 32'h11AA_0000) begin
            n_errors++; $display("FAIL ovf_err got err=%b stb=%b q=%h exp 1/0/11aa0000",
                                 frame_err, wr_stb, reg_q);
        end
`ifdef SPI_REG_ERRCNT_EN
        n_checks++;
        if (err_cnt !== 8'h01) begin
            n_errors++; $display("FAIL ovf_err_cnt got=%h exp=01", err_cnt);
        end
`endif
        tick();
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_errors++; $display("FAIL ovf_err_pulse got=%b exp=0", frame_err);
        end
        cs_high();
    endtask

    task automatic test_clear();
        cs_low();
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        cs_high();
        n_checks++;
        if (reg_q !== 32'h0403_0201) begin
            n_errors++; $display("FAIL clear_preload got=%h exp=04030201", reg_q);
        end
        cs_low();
        send_byte(8'h20);
        n_checks++;
        if (reg_q !== 32'h0 || wr_stb !== 1'b0 || frame_err !== 1'b0) begin
            n_errors++; $display("FAIL clear got q=%h stb=%b err=%b exp 0/0/0",
                                 reg_q, wr_stb, frame_err);
        end
        send_byte(8'h99);
        n_checks++;
        if (frame_err !== 1'b1 || reg_q !== 32'h0) begin
            n_errors++; $display("FAIL clear_extra got err=%b q=%h exp 1/0", frame_err, reg_q);
        end
        cs_high();
    endtask

    task automatic test_bad_opcode();
        cs_low();
        send_byte(8'h70);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_errors++; $display("FAIL badop_err got=%b exp=1", frame_err);
        end
        send_byte(8'h01);
        n_checks++;
        if (frame_err !== 1'b0 || wr_stb !== 1'b0 || reg_q !== 32'h0) begin
            n_errors++; $display("FAIL badop_drain got err=%b stb=%b q=%h exp 0/0/0",
                                 frame_err, wr_stb, reg_q);
        end
        cs_high();
        // Command address at NUM_REGS is out of range
        cs_low();
        send_byte(8'h14);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_errors++; $display("FAIL badaddr_err got=%b exp=1", frame_err);
        end
        send_byte(8'h66);
        n_checks++;
        if (wr_stb !== 1'b0 || reg_q !== 32'h0) begin
            n_errors++; $display("FAIL badaddr_drain got stb=%b q=%h exp 0/0", wr_stb, reg_q);
        end
        cs_high();
`ifdef SPI_REG_ERRCNT_EN
        n_checks++;
        if (err_cnt !== 8'h04) begin
            n_errors++; $display("FAIL badop_err_cnt got=%h exp=04", err_cnt);
        end
`endif
    endtask

    task automatic test_cs_same_cycle();
        cs_low();
        send_byte(8'h10);
        tick();
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        rx_cs    = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (wr_stb !== 1'b1 || wr_addr !== 4'h0 || reg_q !== 32'h0000_005A) begin
            n_errors++; $display("FAIL cs_same got stb=%b addr=%h q=%h exp 1/0/0000005a",
                                 wr_stb, wr_addr, reg_q);
        end
        cs_low();
        send_byte(8'h11);
        n_checks++;
        if (wr_stb !== 1'b0 || frame_err !== 1'b0) begin
            n_errors++; $display("FAIL cs_next_cmd got stb=%b err=%b exp 0/0", wr_stb, frame_err);
        end
        send_byte(8'h33);
        n_checks++;
        if (wr_stb !== 1'b1 || wr_addr !== 4'h1 || reg_q !== 32'h0000_335A) begin
            n_errors++; $display("FAIL cs_next_data got stb=%b addr=%h q=%h exp 1/1/0000335a",
                                 wr_stb, wr_addr, reg_q);
        end
        cs_high();
    endtask

    task automatic test_back_to_back();
        cs_low();
        send_byte(8'h10);
        tick();
        rx_data  = 8'hC1;
        rx_valid = 1'b1;
        tick();
        n_checks++;
        if (wr_stb !== 1'b1 || wr_addr !== 4'h0) begin
            n_errors++; $display("FAIL b2b_0 got stb=%b addr=%h exp 1/0", wr_stb, wr_addr);
        end
        rx_data = 8'hC2;
        tick();
        n_checks++;
        if (wr_stb !== 1'b1 || wr_addr !== 4'h1) begin
            n_errors++; $display("FAIL b2b_1 got stb=%b addr=%h exp 1/1", wr_stb, wr_addr);
        end
        rx_data = 8'hC3;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (wr_stb !== 1'b1 || wr_addr !== 4'h2 || reg_q !== 32'h00C3_C2C1) begin
            n_errors++; $display("FAIL b2b_2 got stb=%b addr=%h q=%h exp 1/2/00c3c2c1",
                                 wr_stb, wr_addr, reg_q);
        end
        cs_high();
        // NOP frame: trailing bytes ignored silently
        cs_low();
        send_byte(8'h00);
        send_byte(8'hFF);
        n_checks++;
        if (frame_err !== 1'b0 || wr_stb !== 1'b0 || reg_q !== 32'h00C3_C2C1) begin
            n_errors++; $display("FAIL nop got err=%b stb=%b q=%h exp 0/0/00c3c2c1",
                                 frame_err, wr_stb, reg_q);
        end
        cs_high();
        // Empty frame and WRITE without data are both harmless
        cs_low();
        cs_high();
        cs_low();
        send_byte(8'h11);
        cs_high();
        n_checks++;
        if (frame_err !== 1'b0 || reg_q !== 32'h00C3_C2C1) begin
            n_errors++; $display("FAIL empty_frames got err=%b q=%h exp 0/00c3c2c1",
                                 frame_err, reg_q);
        end
    endtask

    task automatic test_reset_midframe();
        cs_low();
        send_byte(8'h10);
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        n_checks++;
        if (reg_q !== 32'h0 || wr_addr !== 4'h0) begin
            n_errors++; $display("FAIL midrst_state got q=%h addr=%h exp 0/0", reg_q, wr_addr);
        end
        send_byte(8'h77);
        n_checks++;
        if (wr_stb !== 1'b0 || frame_err !== 1'b0 || reg_q !== 32'h0) begin
            n_errors++; $display("FAIL midrst_b0 got stb=%b err=%b q=%h exp 0/0/0",
                                 wr_stb, frame_err, reg_q);
        end
        send_byte(8'h12);
        send_byte(8'h44);
        n_checks++;
        if (wr_stb !== 1'b0 || reg_q !== 32'h0) begin
            n_errors++; $display("FAIL midrst_partial got stb=%b q=%h exp 0/0", wr_stb, reg_q);
        end
        cs_high();
`ifdef SPI_REG_ERRCNT_EN
        n_checks++;
        if (err_cnt !== 8'h00) begin
            n_errors++; $display("FAIL midrst_err_cnt got=%h exp=00", err_cnt);
        end
`endif
        // A clean frame after the drained one decodes normally
        cs_low();
        send_byte(8'h10);
        send_byte(8'h9C);
        n_checks++;
        if (wr_stb !== 1'b1 || reg_q !== 32'h0000_009C) begin
            n_errors++; $display("FAIL midrst_recover got stb=%b q=%h exp 1/0000009c", wr_stb, reg_q);
        end
        cs_high();
    endtask

    initial begin
        test_reset();
        test_write();
        test_overflow();
        test_clear();
        test_bad_opcode();
        test_cs_same_cycle();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
